// File: rtl/foreground_scanline.sv
// foreground_scanline: per-line sprite evaluator with double-buffered line banks and pixel compositor.
// Overflow flag register is built only when FOREGROUND_SCANLINE_OVERFLOW_EN is defined.
module foreground_scanline #(
  parameter int NUM_OBJECTS     = 64,
  parameter int MAX_PER_LINE    = 8,
  parameter int VRAM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 current_x,
  input  logic [7:0]                 current_y,
  input  logic                       hblank_start,
  input  logic                       writable,
  input  logic [7:0]                 data_in,
  input  logic [VRAM_ADDR_WIDTH-1:0] address,
  input  logic                       write_enable,
  output logic [1:0]                 r,
  output logic [1:0]                 g,
  output logic [1:0]                 b,
  output logic                       valid,
  output logic                       busy,
  output logic                       overflow
);
  localparam int SW = MAX_PER_LINE > 1 ? $clog2(MAX_PER_LINE) : 1;
  localparam int NS = 2 ** SW;
  typedef enum logic [1:0] {IDLE, SCAN, FETCH, SWAP} state_t;
  state_t state, state_nx;
  logic [7:0] pmf [512];
  logic [7:0] obm [256];
  logic [7:0] target_y;
  logic [5:0] idx;
  logic [SW:0] cnt, fidx;
  logic [5:0] slot_obj [NS];
  logic fsel;
  logic        bvalid [2][NS];
  logic [15:0] bline  [2][NS];
  logic [7:0]  bx     [2][NS];
  logic        bhf    [2][NS];
  logic [2:0]  bcol   [2][NS];
  logic [7:0] obj_y, fx;
  logic [6:0] fa;
  logic [2:0] fc, row;
  logic [5:0] fo;
  logic hit, room, last, take;
  always_ff @(posedge clk)
    if (write_enable && writable) begin
      if (address < VRAM_ADDR_WIDTH'(512)) pmf[address[8:0]] <= data_in;
      else if ((address >> 8) == VRAM_ADDR_WIDTH'(8)) obm[address[7:0]] <= data_in;
    end
  assign obj_y = obm[{idx, 2'b01}];
  assign hit   = ({1'b0, obj_y} <= {1'b0, target_y}) && ({1'b0, target_y} < {1'b0, obj_y} + 9'd8);
  assign room  = cnt < (SW+1)'(MAX_PER_LINE);
  assign last  = idx == 6'(NUM_OBJECTS - 1);
  assign take  = state == SCAN && hit && room;
  assign fo    = slot_obj[fidx[SW-1:0]];
  assign fx    = obm[{fo, 2'b00}];
  assign fa    = obm[{fo, 2'b10}][6:0];
  assign fc    = obm[{fo, 2'b11}][2:0];
  assign row   = 3'(target_y - obm[{fo, 2'b01}]) ^ {3{fa[5]}};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = hblank_start                          ? SCAN :
               state == SCAN && last                 ? ((cnt == '0 && !take) ? SWAP : FETCH) :
               state == FETCH && fidx == cnt - 1'b1  ? SWAP :
               state == SWAP                         ? IDLE : state;
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fsel     <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      fidx     <= '0;
      target_y <= '0;
      for (int s = 0; s < NS; s++) begin
        bvalid[0][s] <= 1'b0;
        bvalid[1][s] <= 1'b0;
      end
    end else if (hblank_start) begin
      target_y <= current_y + 8'd1;
      idx      <= '0;
      cnt      <= '0;
      fidx     <= '0;
      for (int s = 0; s < NS; s++) bvalid[~fsel][s] <= 1'b0;
    end else if (state == SCAN) begin
      idx <= idx + 6'd1;
      if (take) cnt <= cnt + 1'b1;
    end else if (state == FETCH) begin
      fidx <= fidx + 1'b1;
      bvalid[~fsel][fidx[SW-1:0]] <= 1'b1;
    end else if (state == SWAP) begin
      fsel <= ~fsel;
      for (int s = 0; s < NS; s++) bvalid[fsel][s] <= 1'b0;
    end
  // Bank payload needs no reset: it is only observed through bvalid.
  always_ff @(posedge clk)
    if (!hblank_start) begin
      if (take) slot_obj[cnt[SW-1:0]] <= idx;
      if (state == FETCH) begin
        bline[~fsel][fidx[SW-1:0]] <= {pmf[{fa[4:0], row, 1'b0}], pmf[{fa[4:0], row, 1'b1}]};
        bx[~fsel][fidx[SW-1:0]]    <= fx;
        bhf[~fsel][fidx[SW-1:0]]   <= fa[6];
        bcol[~fsel][fidx[SW-1:0]]  <= fc;
      end
    end
`ifdef FOREGROUND_SCANLINE_OVERFLOW_EN
  logic ovf_back;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ovf_back <= 1'b0;
      overflow <= 1'b0;
    end else if (hblank_start) ovf_back <= 1'b0;
    else if (state == SCAN && hit && !room) ovf_back <= 1'b1;
    else if (state == SWAP) begin
      overflow <= ovf_back;
      ovf_back <= 1'b0;
    end
`else
  assign overflow = 1'b0;
`endif
  logic [1:0] spix [MAX_PER_LINE];
  logic       son  [MAX_PER_LINE];
  genvar s;
  for (s = 0; s < MAX_PER_LINE; s++) begin : g_slot
    logic [2:0] c;
    assign c       = 3'(current_x - bx[fsel][s]) ^ {3{bhf[fsel][s]}};
    assign spix[s] = bline[fsel][s][{~c, 1'b0} +: 2];
    assign son[s]  = bvalid[fsel][s] && ({1'b0, bx[fsel][s]} <= {1'b0, current_x}) &&
                     ({1'b0, current_x} < {1'b0, bx[fsel][s]} + 9'd8) && spix[s] != 2'b00;
  end
  logic [1:0] pix;
  logic [2:0] col;
  always_comb begin
    pix = '0;
    col = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--)
      if (son[i]) begin
        pix = spix[i];
        col = bcol[fsel][i];
      end
    valid = pix != 2'b00;
    r = pix & {2{col[2]}};
    g = pix & {2{col[1]}};
    b = pix & {2{col[0]}};
  end
endmodule

// File: doc/foreground_scanline.md
FOREGROUND_SCANLINE -- requirements
Module: foreground_scanline

Interface
REQ-001 Parameter NUM_OBJECTS, default 64, number of OBM entries scanned per line (1..64).
REQ-002 Parameter MAX_PER_LINE, default 8, sprite slots per scanline (1..16).
REQ-003 clk  input  1  pixel clock, 12.5875 MHz.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 current_x, current_y  input  8 each  video timing position.
REQ-006 hblank_start  input  1  one-cycle pulse after the last pixel of line current_y.
REQ-007 writable  input  1  VRAM write permitted.
REQ-008 data_in  input  8; address  input  VRAM_ADDR_WIDTH; write_enable  input  1  VRAM write port.
REQ-009 r, g, b  output  2 each  foreground pixel colour.
REQ-010 valid  output  1  foreground pixel opaque at current position.
REQ-011 busy  output  1  line evaluation in progress.
REQ-012 overflow  output  1  more than MAX_PER_LINE objects hit the last evaluated line.

Function
REQ-013 PMF (512x8, 0x000-0x1FF) and OBM (256x8, 0x800-0x8FF) SHALL be written on the clk edge when write_enable && writable; other addresses ignored; OBM byte layout: 0=x, 1=y, 2={-,hflip,vflip,pmfa[4:0]}, 3=colour[2:0].
REQ-014 FSM states IDLE, SCAN, FETCH, SWAP; IDLE->SCAN on hblank_start, latching target_y = current_y+1 mod 256 (255 -> 0).
REQ-015 SCAN SHALL examine one object per cycle, index 0 to NUM_OBJECTS-1, exactly NUM_OBJECTS cycles.
REQ-016 Hit test: object_y <= target_y < object_y+8, evaluated in 9 bits (no wrap; y>=249 clips at bottom).
REQ-017 On hit with fewer than MAX_PER_LINE slots filled: record index in next slot in ascending index order; on hit with all slots full: set overflow flag of the back bank, object dropped.
REQ-018 FETCH SHALL take one cycle per filled slot (zero cycles if none): row = target_y-object_y (3 bits), inverted (7-row) if vflip; latch 16-bit pattern line {PMF[{pmfa,row,0}],PMF[{pmfa,row,1}]}, x, hflip, colour into back bank.
REQ-019 SWAP (1 cycle) SHALL exchange front and back banks, copy back overflow to overflow output, clear new back bank, return to IDLE.
REQ-020 busy SHALL be high from the cycle after hblank_start through SWAP; total = NUM_OBJECTS + hits + 1 cycles.
REQ-021 hblank_start while busy SHALL abort, clear back bank, relatch target_y and restart SCAN at index 0; front bank unchanged.
REQ-022 Pixel output combinational from front bank: slot hits when slot_x <= current_x < slot_x+8 (9-bit); column c = current_x-slot_x, inverted if hflip; pixel = line[{7-c,1'b0} +: 2].
REQ-023 Pixel 2'b00 transparent; lowest-numbered slot with opaque pixel wins; valid=1 iff a winner exists.
REQ-024 r/g/b = winner pixel AND {2{colour[2]}}/{2{colour[1]}}/{2{colour[0]}}; all 0 when valid=0.
REQ-025 OBM/PMF writes during SCAN/FETCH take effect for entries not yet read; no hazard protection.

Reset
REQ-026 On rst low: FSM IDLE, busy=0, overflow=0, both banks' slot-valid bits cleared, valid=0, r=g=b=0; PMF/OBM contents not reset.
REQ-027 Reset asserted mid-SCAN/FETCH SHALL abandon evaluation; first line after release displays no sprites.

Configuration
REQ-028 Macro FOREGROUND_SCANLINE_OVERFLOW_EN: defined -> REQ-017/019 overflow behaviour as specified; undefined -> overflow driven constant 0, no overflow flag register, excess objects still dropped silently.

Verification
REQ-029 Object 0 at (16,20), pmfa 1, colour 3'b100, pattern row 0 = 16'hC000; hblank_start at y=19 -> on y=20, x=16: valid=1, r=2'b11, g=b=0; x=17: valid=0.
REQ-030 Objects 0..9 all y=40, distinct x, MAX_PER_LINE=8 -> on y=40 objects 8,9 never drawn; overflow=1 after SWAP (0 with macro undefined).
REQ-031 Objects 2 and 5 overlapping at x=50, both opaque -> object 2 colour output; object 2 pixel transparent -> object 5 colour output.
REQ-032 hflip=1, vflip=1, row 7 = 16'h0003 -> on object row 0, column 0 pixel = 2'b11.
REQ-033 hblank_start reissued 10 cycles into SCAN -> busy stays high, completes NUM_OBJECTS+hits+1 cycles after second pulse, prior front bank displayed meanwhile.
REQ-034 rst low for 1 cycle mid-FETCH -> busy=0, valid=0 immediately; next line no sprites; following line correct.
